// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - EX-stage sequencer for the signed/unsigned divider IPs.
// Latches operands, hands them to the selected IP, holds the result until EX takes it.
module div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 req_valid,
  input  logic [1:0]           req_op,
  input  logic [WIDTH-1:0]     req_src1,
  input  logic [WIDTH-1:0]     req_src2,
  input  logic                 res_ack,
  input  logic                 flush,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  output logic                 busy,
  output logic                 s_dvd_tvalid,
  input  logic                 s_dvd_tready,
  output logic                 s_dvs_tvalid,
  input  logic                 s_dvs_tready,
  output logic                 u_dvd_tvalid,
  input  logic                 u_dvd_tready,
  output logic                 u_dvs_tvalid,
  input  logic                 u_dvs_tready,
  output logic [WIDTH-1:0]     dvd_tdata,
  output logic [WIDTH-1:0]     dvs_tdata,
  input  logic                 s_dout_tvalid,
  input  logic [2*WIDTH-1:0]   s_dout_tdata,
  input  logic                 u_dout_tvalid,
  input  logic [2*WIDTH-1:0]   u_dout_tdata
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEND  = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t state;
  logic   op_u;
  logic   op_mod;
  logic   dvd_sent;
  logic   dvs_sent;
  logic   kill;

  logic               dvd_hs;
  logic               dvs_hs;
  logic               dvd_fin;
  logic               dvs_fin;
  logic               dout_valid;
  logic [2*WIDTH-1:0] dout_data;

  always_comb begin
    dvd_hs     = op_u ? (u_dvd_tvalid & u_dvd_tready) : (s_dvd_tvalid & s_dvd_tready);
    dvs_hs     = op_u ? (u_dvs_tvalid & u_dvs_tready) : (s_dvs_tvalid & s_dvs_tready);
    dvd_fin    = dvd_sent | dvd_hs;
    dvs_fin    = dvs_sent | dvs_hs;
    dout_valid = op_u ? u_dout_tvalid : s_dout_tvalid;
    dout_data  = op_u ? u_dout_tdata : s_dout_tdata;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= IDLE;
      op_u         <= 1'b0;
      op_mod       <= 1'b0;
      dvd_sent     <= 1'b0;
      dvs_sent     <= 1'b0;
      kill         <= 1'b0;
      done         <= 1'b0;
      result       <= '0;
      dvd_tdata    <= '0;
      dvs_tdata    <= '0;
      s_dvd_tvalid <= 1'b0;
      s_dvs_tvalid <= 1'b0;
      u_dvd_tvalid <= 1'b0;
      u_dvs_tvalid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && !flush) begin
            op_u         <= req_op[1];
            op_mod       <= req_op[0];
            dvd_tdata    <= req_src1;
            dvs_tdata    <= req_src2;
            dvd_sent     <= 1'b0;
            dvs_sent     <= 1'b0;
            kill         <= 1'b0;
            s_dvd_tvalid <= ~req_op[1];
            s_dvs_tvalid <= ~req_op[1];
            u_dvd_tvalid <= req_op[1];
            u_dvs_tvalid <= req_op[1];
            state        <= SEND;
          end
        end
        SEND: begin
          // A flushed divide still completes its handshakes; the IP result is drained later.
          dvd_sent     <= dvd_fin;
          dvs_sent     <= dvs_fin;
          s_dvd_tvalid <= ~op_u & ~dvd_fin;
          s_dvs_tvalid <= ~op_u & ~dvs_fin;
          u_dvd_tvalid <= op_u & ~dvd_fin;
          u_dvs_tvalid <= op_u & ~dvs_fin;
          kill         <= kill | flush;
          if (dvd_fin && dvs_fin)
            state <= (kill || flush) ? DRAIN : WAIT;
        end
        WAIT: begin
          if (dout_valid && flush) begin
            state <= IDLE;
          end else if (dout_valid) begin
            result <= op_mod ? dout_data[WIDTH-1:0] : dout_data[2*WIDTH-1:WIDTH];
            done   <= 1'b1;
            state  <= DONE;
          end else if (flush) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (dout_valid)
            state <= IDLE;
        end
        DONE: begin
          if (res_ack || flush) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - scoreboard bench for div_ctrl with directed divider-IP stimulus.
module tb_div_ctrl;
  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] req_src1, req_src2;
  logic        res_ack, flush;
  logic        done, busy;
  logic [31:0] result;
  logic        s_dvd_tvalid, s_dvd_tready, s_dvs_tvalid, s_dvs_tready;
  logic        u_dvd_tvalid, u_dvd_tready, u_dvs_tvalid, u_dvs_tready;
  logic [31:0] dvd_tdata, dvs_tdata;
  logic        s_dout_tvalid, u_dout_tvalid;
  logic [63:0] s_dout_tdata, u_dout_tdata;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic        done_q = 1'b0;

  div_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_op(req_op),
    .req_src1(req_src1), .req_src2(req_src2), .res_ack(res_ack), .flush(flush),
    .done(done), .result(result), .busy(busy),
    .s_dvd_tvalid(s_dvd_tvalid), .s_dvd_tready(s_dvd_tready),
    .s_dvs_tvalid(s_dvs_tvalid), .s_dvs_tready(s_dvs_tready),
    .u_dvd_tvalid(u_dvd_tvalid), .u_dvd_tready(u_dvd_tready),
    .u_dvs_tvalid(u_dvs_tvalid), .u_dvs_tready(u_dvs_tready),
    .dvd_tdata(dvd_tdata), .dvs_tdata(dvs_tdata),
    .s_dout_tvalid(s_dout_tvalid), .s_dout_tdata(s_dout_tdata),
    .u_dout_tvalid(u_dout_tvalid), .u_dout_tdata(u_dout_tdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every rising done is matched against the oldest queued expectation.
  always @(negedge clk) begin
    if (resetn && done && !done_q) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got result %h expected no done", result);
      end else begin
        check("result", {32'h0, result}, {32'h0, exp_q.pop_front()});
      end
    end
    done_q = done;
  end

  task automatic set_ready(input logic v);
    s_dvd_tready = v; s_dvs_tready = v; u_dvd_tready = v; u_dvs_tready = v;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b;
  endtask

  // Full divide with all treadys high; dout presented at cycle 8, done expected at 9.
  task automatic run_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] dd, input logic [31:0] ev);
    set_ready(1'b1);
    issue(op, a, b);
    tick();
    req_valid = 1'b0;
    check("send_dvd_tvalid", {63'h0, op[1] ? u_dvd_tvalid : s_dvd_tvalid}, 64'h1);
    check("send_dvd_tdata", {32'h0, dvd_tdata}, {32'h0, a});
    check("send_dvs_tdata", {32'h0, dvs_tdata}, {32'h0, b});
    tick();
    check("wait_tvalid", {63'h0, s_dvd_tvalid | u_dvd_tvalid}, 64'h0);
    repeat (6) tick();
    check("wait_no_done", {63'h0, done}, 64'h0);
    if (op[1]) begin u_dout_tvalid = 1'b1; u_dout_tdata = dd; end
    else       begin s_dout_tvalid = 1'b1; s_dout_tdata = dd; end
    exp_q.push_back(ev);
    tick();
    s_dout_tvalid = 1'b0; u_dout_tvalid = 1'b0;
    check("done_after_dout", {63'h0, done}, 64'h1);
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    check("done_cleared", {63'h0, done}, 64'h0);
    check("idle_after_ack", {63'h0, busy}, 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_src1 = '0; req_src2 = '0;
    res_ack = 1'b0; flush = 1'b0; set_ready(1'b0);
    s_dout_tvalid = 1'b0; u_dout_tvalid = 1'b0; s_dout_tdata = '0; u_dout_tdata = '0;
    tick(); tick();
    check("rst_done", {63'h0, done}, 64'h0);
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_tvalids", {60'h0, s_dvd_tvalid, s_dvs_tvalid, u_dvd_tvalid, u_dvs_tvalid}, 64'h0);
    check("rst_result", {32'h0, result}, 64'h0);
    resetn = 1'b1;
    tick();

    run_div(2'b00, 32'hFFFFFFF9, 32'h2, {32'hFFFFFFFD, 32'hFFFFFFFF}, 32'hFFFFFFFD);
    run_div(2'b01, 32'hFFFFFFF9, 32'h2, {32'hFFFFFFFD, 32'hFFFFFFFF}, 32'hFFFFFFFF);
    run_div(2'b10, 32'd100, 32'd7, {32'd14, 32'd2}, 32'd14);

    // div.wu with staggered treadys, then flush in WAIT and drain
    s_dvd_tready = 1'b1; s_dvs_tready = 1'b1; u_dvd_tready = 1'b1; u_dvs_tready = 1'b0;
    issue(2'b10, 32'd100, 32'd7);
    tick(); // c1
    req_valid = 1'b0;
    check("c1_u_dvd", {63'h0, u_dvd_tvalid}, 64'h1);
    check("c1_u_dvs", {63'h0, u_dvs_tvalid}, 64'h1);
    check("c1_s_tv", {62'h0, s_dvd_tvalid, s_dvs_tvalid}, 64'h0);
    tick(); // c2
    u_dvd_tready = 1'b0;
    check("c2_u_dvd", {63'h0, u_dvd_tvalid}, 64'h0);
    check("c2_u_dvs", {63'h0, u_dvs_tvalid}, 64'h1);
    tick(); // c3
    u_dvs_tready = 1'b1;
    check("c3_u_dvs", {63'h0, u_dvs_tvalid}, 64'h1);
    check("c3_s_tv", {62'h0, s_dvd_tvalid, s_dvs_tvalid}, 64'h0);
    tick(); // c4
    u_dvs_tready = 1'b0;
    check("c4_wait_tv", {62'h0, u_dvd_tvalid, u_dvs_tvalid}, 64'h0);
    check("c4_busy", {63'h0, busy}, 64'h1);
    tick(); // c5
    for (int c = 5; c <= 12; c++) begin
      flush = (c == 5);
      if (c == 8) issue(2'b11, 32'd9, 32'd4);
      if (c == 12) begin u_dout_tvalid = 1'b1; u_dout_tdata = {32'd14, 32'd2}; end
      check($sformatf("drain_busy_c%0d", c), {63'h0, busy}, 64'h1);
      check($sformatf("drain_done_c%0d", c), {63'h0, done}, 64'h0);
      if (c == 9)
        check("ignored_req", {62'h0, u_dvd_tvalid, s_dvd_tvalid}, 64'h0);
      tick();
      req_valid = 1'b0;
      flush = 1'b0;
    end
    u_dout_tvalid = 1'b0; // c13
    check("c13_idle", {63'h0, busy}, 64'h0);
    set_ready(1'b1);
    issue(2'b11, 32'd100, 32'd7);
    tick(); // c14
    req_valid = 1'b0;
    check("c14_send", {63'h0, u_dvd_tvalid}, 64'h1);
    tick(); // c15 WAIT
    u_dout_tvalid = 1'b1; u_dout_tdata = {32'd14, 32'd2};
    exp_q.push_back(32'd2);
    tick();
    u_dout_tvalid = 1'b0;
    check("modwu_done", {63'h0, done}, 64'h1);
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;

    // flush in SEND with stalled treadys: tvalid must stay up until handshake
    set_ready(1'b0);
    issue(2'b00, 32'd20, 32'd3);
    tick(); // c1
    req_valid = 1'b0;
    flush = 1'b1;
    check("fs_c1_tv", {62'h0, s_dvd_tvalid, s_dvs_tvalid}, 64'h3);
    tick(); // c2
    flush = 1'b0;
    check("fs_c2_tv", {62'h0, s_dvd_tvalid, s_dvs_tvalid}, 64'h3);
    tick(); // c3
    check("fs_c3_tv", {62'h0, s_dvd_tvalid, s_dvs_tvalid}, 64'h3);
    set_ready(1'b1);
    tick(); // c4 DRAIN
    check("fs_c4_tv", {62'h0, s_dvd_tvalid, s_dvs_tvalid}, 64'h0);
    check("fs_c4_busy", {63'h0, busy}, 64'h1);
    s_dout_tvalid = 1'b1; s_dout_tdata = {32'd6, 32'd2};
    tick();
    s_dout_tvalid = 1'b0;
    check("fs_idle", {63'h0, busy}, 64'h0);
    check("fs_no_done", {63'h0, done}, 64'h0);

    // DONE held without res_ack; IP dout noise must not disturb the result
    issue(2'b00, 32'd20, 32'd3);
    tick();
    req_valid = 1'b0;
    tick();
    s_dout_tvalid = 1'b1; s_dout_tdata = {32'd6, 32'd2};
    exp_q.push_back(32'd6);
    tick();
    s_dout_tdata = {32'd99, 32'd99};
    for (int i = 0; i < 4; i++) begin
      check($sformatf("hold_done_%0d", i), {63'h0, done}, 64'h1);
      check($sformatf("hold_result_%0d", i), {32'h0, result}, 64'd6);
      tick();
    end
    s_dout_tvalid = 1'b0;
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    check("hold_ack_done", {63'h0, done}, 64'h0);
    check("hold_ack_busy", {63'h0, busy}, 64'h0);

    // flush together with dout in WAIT discards the result
    issue(2'b01, 32'd20, 32'd3);
    tick();
    req_valid = 1'b0;
    tick();
    s_dout_tvalid = 1'b1; s_dout_tdata = {32'd6, 32'd2}; flush = 1'b1;
    tick();
    s_dout_tvalid = 1'b0; flush = 1'b0;
    check("fd_busy", {63'h0, busy}, 64'h0);
    check("fd_done", {63'h0, done}, 64'h0);
    check("fd_result", {32'h0, result}, 64'd6);

    // reset while waiting
    issue(2'b10, 32'h1234, 32'h56);
    tick();
    req_valid = 1'b0;
    tick();
    resetn = 1'b0;
    tick();
    check("rw_busy", {63'h0, busy}, 64'h0);
    check("rw_done", {63'h0, done}, 64'h0);
    check("rw_result", {32'h0, result}, 64'h0);
    check("rw_tvalids", {60'h0, s_dvd_tvalid, s_dvs_tvalid, u_dvd_tvalid, u_dvs_tvalid}, 64'h0);
    check("rw_tdata", {dvd_tdata, dvs_tdata}, 64'h0);
    resetn = 1'b1;
    tick(); tick();

    check("queue_empty", 64'(exp_q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
